axi2apb_bridge: RTL and testbench

AXI2APB_BRIDGE -- requirements
Module: axi2apb_bridge

---
 rtl/axi2apb_pkg.sv | 26 ++
 rtl/axi2apb_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_axi2apb_bridge.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi2apb_pkg.sv
// rtl/axi2apb_pkg.sv - shared states, response/burst codes and beat addressing for the AXI-to-APB bridge
package axi2apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    WSETUP,
    WACCESS,
    BRESP,
    RSETUP,
    RACCESS,
    RDATA
  } state_t;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [31:0] BEAT_BYTES  = 32'd4;

  // Every non-FIXED burst type advances one 32-bit word and wraps at 4 GiB.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? addr : addr + BEAT_BYTES;
  endfunction

endpackage

// File: rtl/axi2apb_bridge.sv
// rtl/axi2apb_bridge.sv - single-outstanding AXI3 slave to APB master bridge, 4-byte beats
// Optional slave-error propagation is built when AXI2APB_SLVERR_EN is defined.
module axi2apb_bridge
  import axi2apb_pkg::*;
#(
  parameter int WR_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  awid_i,
  input  logic [31:0] awaddr_i,
  input  logic [3:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [3:0]  wid_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [3:0]  rid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic        pready_i,
  input  logic [31:0] prdata_i,
  input  logic        pslverr_i
);

  state_t      state_q, state_d;
  logic [3:0]  id_q, len_q, cnt_q, wstrb_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  burst_q;
  logic        last_beat, aw_hs, ar_hs, w_hs, apb_done, r_hs;

  // Beat size is fixed and write bursts end on the internal count.
`ifdef AXI2APB_SLVERR_EN
  logic        unused_inputs;
  assign unused_inputs = ^{awsize_i, arsize_i, wid_i, wlast_i};
`else
  logic        unused_inputs;
  assign unused_inputs = ^{awsize_i, arsize_i, wid_i, wlast_i, pslverr_i};
`endif

  assign last_beat = (cnt_q == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    awready_o = 1'b0;
    arready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    rvalid_o  = 1'b0;
    rlast_o   = 1'b0;
    psel_o    = 1'b0;
    penable_o = 1'b0;
    pwrite_o  = 1'b0;
    case (state_q)
      // Readies follow the valids directly, so they must be masked while reset is held.
      IDLE: if (rst_n) begin
        if (awvalid_i && (WR_PRIORITY != 0 || !arvalid_i)) begin
          awready_o = 1'b1;
          state_d   = WDATA;
        end else if (arvalid_i) begin
          arready_o = 1'b1;
          state_d   = RSETUP;
        end
      end
      WDATA: begin
        wready_o = 1'b1;
        if (wvalid_i) state_d = WSETUP;
      end
      WSETUP: begin
        psel_o   = 1'b1;
        pwrite_o = 1'b1;
        state_d  = WACCESS;
      end
      WACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        pwrite_o  = 1'b1;
        if (pready_i) state_d = last_beat ? BRESP : WDATA;
      end
      BRESP: begin
        bvalid_o = 1'b1;
        if (bready_i) state_d = IDLE;
      end
      RSETUP: begin
        psel_o  = 1'b1;
        state_d = RACCESS;
      end
      RACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i) state_d = RDATA;
      end
      RDATA: begin
        rvalid_o = 1'b1;
        rlast_o  = last_beat;
        if (rready_i) state_d = last_beat ? IDLE : RSETUP;
      end
      default: state_d = IDLE;
    endcase
  end

  assign aw_hs    = awready_o;
  assign ar_hs    = arready_o;
  assign w_hs     = wready_o & wvalid_i;
  assign apb_done = penable_o & pready_i;
  assign r_hs     = rvalid_o & rready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      if (aw_hs) begin
        id_q    <= awid_i;
        addr_q  <= awaddr_i;
        len_q   <= awlen_i;
        burst_q <= awburst_i;
        cnt_q   <= '0;
      end else if (ar_hs) begin
        id_q    <= arid_i;
        addr_q  <= araddr_i;
        len_q   <= arlen_i;
        burst_q <= arburst_i;
        cnt_q   <= '0;
      end
      if (w_hs) begin
        wdata_q <= wdata_i;
        wstrb_q <= wstrb_i;
      end
      if (apb_done && !pwrite_o) rdata_q <= prdata_i;
      // Writes advance after the APB completes; reads only once the beat is taken on R.
      if ((apb_done && pwrite_o && !last_beat) || (r_hs && !last_beat)) begin
        cnt_q  <= cnt_q + 4'd1;
        addr_q <= next_addr(addr_q, burst_q);
      end
    end
  end

`ifdef AXI2APB_SLVERR_EN
  logic       err_q;
  logic [1:0] rresp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= 1'b0;
      rresp_q <= RESP_OKAY;
    end else begin
      if (aw_hs) err_q <= 1'b0;
      else if (apb_done && pwrite_o && pslverr_i) err_q <= 1'b1;
      if (apb_done && !pwrite_o) rresp_q <= pslverr_i ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign bresp_o = (bvalid_o && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign rresp_o = rvalid_o ? rresp_q : RESP_OKAY;
`else
  assign bresp_o = RESP_OKAY;
  assign rresp_o = RESP_OKAY;
`endif

  assign bid_o    = id_q;
  assign rid_o    = id_q;
  assign rdata_o  = rdata_q;
  assign paddr_o  = addr_q;
  assign pwdata_o = wdata_q;
  assign pstrb_o  = pwrite_o ? wstrb_q : 4'b0000;

endmodule

// File: tb/tb_axi2apb_bridge.sv
// tb/tb_axi2apb_bridge.sv - randomized directed bench for axi2apb_bridge with a word-memory APB slave model
module tb_axi2apb_bridge;

  localparam int WAIT_MAX = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awid_i, awlen_i, wid_i, wstrb_i, arid_i, arlen_i;
  logic [31:0] awaddr_i, wdata_i, araddr_i, prdata_i;
  logic [2:0]  awsize_i, arsize_i;
  logic [1:0]  awburst_i, arburst_i;
  logic        awvalid_i, wlast_i, wvalid_i, bready_i, arvalid_i, rready_i, pready_i, pslverr_i;
  logic        awready_o, wready_o, bvalid_o, arready_o, rlast_o, rvalid_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [3:0]  bid_o, rid_o, pstrb_o;
  logic [1:0]  bresp_o, rresp_o;
  logic [31:0] rdata_o, paddr_o, pwdata_o;

  int passed = 0;
  int total  = 0;
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  axi2apb_bridge #(.WR_PRIORITY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pready_i(pready_i), .prdata_i(prdata_i),
    .pslverr_i(pslverr_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [1:0] burst, input int i);
    return (burst == 2'b00) ? base : base + 32'(4 * i);
  endfunction

  function automatic logic [1:0] exp_resp(input bit err);
`ifdef AXI2APB_SLVERR_EN
    return err ? 2'b10 : 2'b00;
`else
    return 2'b00;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {23'b0, awready_o, arready_o, wready_o, bvalid_o, rvalid_o,
                        rlast_o, psel_o, penable_o, pwrite_o}, 32'h0);
    chk({tag, "_paddr"}, paddr_o, 32'h0);
    chk({tag, "_pwdata"}, pwdata_o, 32'h0);
    chk({tag, "_rdata"}, rdata_o, 32'h0);
    chk({tag, "_fields"}, {16'b0, pstrb_o, bresp_o, rresp_o, bid_o, rid_o}, 32'h0);
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] base, input logic [3:0] len,
                           input logic [1:0] burst, input int stall, input int err_beat,
                           input bit fixed_a5);
    logic [31:0] a, d, old;
    logic [3:0]  s;
    int n, pen;
    awid_i = id; awaddr_i = base; awlen_i = len; awburst_i = burst;
    awsize_i = 3'($urandom_range(0, 7)); awvalid_i = 1'b1;
    #1; n = 0;
    while (!awready_o && n < WAIT_MAX) begin @(negedge clk); #1; n++; end
    chk("aw_ready", {31'b0, awready_o}, 32'h1);
    chk("ar_blocked", {31'b0, arready_o}, 32'h0);
    @(negedge clk); awvalid_i = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(base, burst, i);
      d = fixed_a5 ? 32'hA5A5_A5A5 : $urandom;
      s = fixed_a5 ? 4'hF : 4'($urandom_range(1, 15));
      #1; chk("wdata_apb_idle", {30'b0, psel_o, penable_o}, 32'h0);
      wdata_i = d; wstrb_i = s; wid_i = 4'($urandom); wlast_i = (i == int'(len)); wvalid_i = 1'b1;
      n = 0;
      while (!wready_o && n < WAIT_MAX) begin @(negedge clk); #1; n++; end
      chk("w_ready", {31'b0, wready_o}, 32'h1);
      @(negedge clk); wvalid_i = 1'b0; #1;
      chk("wsetup_ctl", {29'b0, psel_o, penable_o, pwrite_o}, 32'h5);
      chk("wsetup_addr", paddr_o, a);
      chk("wsetup_data", pwdata_o, d);
      chk("wsetup_strb", {28'b0, pstrb_o}, {28'b0, s});
      pen = 0;
      for (int k = 0; k <= stall; k++) begin
        @(negedge clk); #1;
        if (psel_o && penable_o && pwrite_o && paddr_o === a && pwdata_o === d && pstrb_o === s) pen++;
        pready_i  = (k == stall);
        pslverr_i = (k == stall) && (i == err_beat);
      end
      @(negedge clk); pready_i = 1'b0; pslverr_i = 1'b0;
      chk("waccess_cycles", 32'(pen), 32'(stall + 1));
      old = mem.exists(a) ? mem[a] : 32'h0;
      for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = d[8*b +: 8];
      mem[a] = old;
    end
    #1;
    chk("bvalid", {31'b0, bvalid_o}, 32'h1);
    chk("bid", {28'b0, bid_o}, {28'b0, id});
    chk("bresp", {30'b0, bresp_o}, {30'b0, exp_resp(err_beat >= 0 && err_beat <= int'(len))});
    chk("bresp_apb_idle", {30'b0, psel_o, penable_o}, 32'h0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    #1; chk("bvalid_hold", {31'b0, bvalid_o}, 32'h1);
    bready_i = 1'b1;
    @(negedge clk); bready_i = 1'b0; #1;
    chk("b_done", {31'b0, bvalid_o}, 32'h0);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] base, input logic [3:0] len,
                          input logic [1:0] burst, input bit idx_data, input int err_beat);
    logic [31:0] a, d;
    int n, pen, stall;
    arid_i = id; araddr_i = base; arlen_i = len; arburst_i = burst;
    arsize_i = 3'($urandom_range(0, 7)); arvalid_i = 1'b1;
    #1; n = 0;
    while (!arready_o && n < WAIT_MAX) begin @(negedge clk); #1; n++; end
    chk("ar_ready", {31'b0, arready_o}, 32'h1);
    chk("aw_blocked", {31'b0, awready_o}, 32'h0);
    @(negedge clk); arvalid_i = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(base, burst, i);
      d = idx_data ? 32'(i) : (mem.exists(a) ? mem[a] : $urandom);
      #1;
      chk("rsetup_ctl", {29'b0, psel_o, penable_o, pwrite_o}, 32'h4);
      chk("rsetup_addr", paddr_o, a);
      chk("rsetup_strb", {28'b0, pstrb_o}, 32'h0);
      stall = $urandom_range(0, 3);
      pen = 0;
      for (int k = 0; k <= stall; k++) begin
        @(negedge clk); #1;
        if (psel_o && penable_o && !pwrite_o && paddr_o === a) pen++;
        pready_i  = (k == stall);
        prdata_i  = (k == stall) ? d : $urandom;
        pslverr_i = (k == stall) && (i == err_beat);
      end
      @(negedge clk); pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = $urandom; #1;
      chk("raccess_cycles", 32'(pen), 32'(stall + 1));
      chk("rvalid", {31'b0, rvalid_o}, 32'h1);
      chk("rdata", rdata_o, d);
      chk("rid", {28'b0, rid_o}, {28'b0, id});
      chk("rlast", {31'b0, rlast_o}, {31'b0, i == int'(len)});
      chk("rresp", {30'b0, rresp_o}, {30'b0, exp_resp(i == err_beat)});
      chk("rdata_apb_idle", {30'b0, psel_o, penable_o}, 32'h0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      #1; chk("rdata_hold", rdata_o, d);
      rready_i = 1'b1;
      @(negedge clk); rready_i = 1'b0;
    end
    #1; chk("r_done", {31'b0, rvalid_o}, 32'h0);
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    {awvalid_i, wvalid_i, bready_i, arvalid_i, rready_i, pready_i, pslverr_i, wlast_i} = '0;
    {awid_i, awlen_i, wid_i, wstrb_i, arid_i, arlen_i} = '0;
    {awaddr_i, wdata_i, araddr_i, prdata_i} = '0;
    {awsize_i, arsize_i, awburst_i, arburst_i} = '0;
    #2 rst_n = 1'b0;
    awvalid_i = 1'b1; arvalid_i = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    check_all_zero("reset");
    awvalid_i = 1'b0; arvalid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Single write, INCR read with index data, FIXED write with long stalls.
    axi_write(4'h1, 32'h0000_1000, 4'd0, 2'b01, 0, -1, 1'b1);
    axi_read(4'hB, 32'h0000_2000, 4'd3, 2'b01, 1'b1, -1);
    axi_write(4'h2, 32'h0000_3000, 4'd1, 2'b00, 5, -1, 1'b0);

    // Slave error on the second beat of a 4-beat write, and on the third beat of its read-back.
    axi_write(4'h4, 32'h0000_8000, 4'd3, 2'b01, 0, 1, 1'b0);
    axi_write(4'h4, 32'h0000_8100, 4'd0, 2'b01, 0, -1, 1'b0);
    axi_read(4'h5, 32'h0000_8000, 4'd3, 2'b01, 1'b0, 2);

    // Simultaneous AW and AR: write first, read accepted only after the B handshake.
    arid_i = 4'h9; araddr_i = 32'h0000_1000; arlen_i = 4'd0; arburst_i = 2'b01; arvalid_i = 1'b1;
    axi_write(4'h3, 32'h0000_4000, 4'd0, 2'b01, 1, -1, 1'b0);
    chk("ar_after_b", {31'b0, arready_o}, 32'h1);
    axi_read(4'h9, 32'h0000_1000, 4'd0, 2'b01, 1'b0, -1);

    // Address wrap at the top of the map, and a WRAP-coded burst treated as incrementing.
    axi_write(4'h6, 32'hFFFF_FFF8, 4'd3, 2'b01, 1, -1, 1'b0);
    axi_read(4'h6, 32'hFFFF_FFF8, 4'd3, 2'b10, 1'b0, -1);

    for (int t = 0; t < 6; t++) begin
      logic [31:0] base;
      base = {20'h000A0, 8'($urandom), 4'h0};
      axi_write(4'($urandom), base, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                $urandom_range(0, 3), -1, 1'b0);
      axi_read(4'($urandom), base, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), 1'b0, -1);
    end

    // Reset while a read waits in the access phase.
    arid_i = 4'h6; araddr_i = 32'h0000_6000; arlen_i = 4'd2; arburst_i = 2'b01; arvalid_i = 1'b1;
    #1; n = 0;
    while (!arready_o && n < WAIT_MAX) begin @(negedge clk); #1; n++; end
    chk("rst_ar_ready", {31'b0, arready_o}, 32'h1);
    @(negedge clk); arvalid_i = 1'b0;
    @(negedge clk); #1;
    chk("rst_pre_raccess", {30'b0, psel_o, penable_o}, 32'h3);
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    check_all_zero("rst_mid");
    @(negedge clk); #1;
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_no_rvalid", {31'b0, rvalid_o}, 32'h0);
    chk("rst_apb_idle", {30'b0, psel_o, penable_o}, 32'h0);
    axi_read(4'h7, 32'h0000_1000, 4'd1, 2'b01, 1'b0, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
